input_sync_reg: RTL
===================

INPUT_SYNC_REG -- requirements
Module: input_sync_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of input bits, legal 1..64.
REQ-002 SHALL have parameter STAGES, default 2: synchronizer depth, legal 2..4.
REQ-003 SHALL have parameter SRMODE, default "CLEAR": reset value of all state; "CLEAR" gives 0, "PRESET" gives 1.
REQ-004 SHALL have parameter DEBOUNCE_CYC, default 4: stability window in CE cycles, legal 1..255; used only with the Configuration macro.
REQ-005 SHALL have port SCLK, input, 1: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port LSR, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port CE, input, 1: clock enable; all state advances only when high.
REQ-008 SHALL have port D, input, WIDTH: asynchronous input bits.
REQ-009 SHALL have port Q, output, WIDTH: synchronized (and optionally debounced) value.
REQ-010 SHALL have ports RISE and FALL, output, WIDTH each: one-cycle per-bit edge pulses of Q.
REQ-011 SHALL have port VALID, output, 1: high once the chain holds real samples.

Function
REQ-012 SHALL implement per bit a STAGES-deep register chain; stage 0 samples D, and Q is the last stage (or the debounced value).
REQ-013 SHALL give latency: a D value present at CE edge n appears on Q after CE edge n+STAGES-1 (no debounce).
REQ-014 SHALL assert RISE[i] (FALL[i]) for exactly one cycle, registered, in the first cycle Q[i] is 1 (0) after being 0 (1).
REQ-015 SHALL force RISE and FALL to 0 in any cycle with CE low, and hold every other register.
REQ-016 SHALL count CE edges after reset with a saturating counter and assert VALID after STAGES CE edges; VALID stays high until the next reset.
REQ-017 SHALL suppress RISE/FALL while VALID is low, so a D different from the reset value produces no edge pulse while the chain fills.
REQ-018 SHALL treat simultaneous multi-bit changes independently per bit; there is no cross-bit coherence guarantee.

Reset
REQ-019 SHALL, on LSR high at an SCLK edge, regardless of CE, load every chain stage and Q with the SRMODE value, clear RISE, FALL, VALID and all counters.
REQ-020 SHALL let LSR take priority over CE and any in-flight debounce count; reset mid-window discards the count.
REQ-021 SHALL hold reset values on the first edge after LSR falls; normal operation resumes from the next CE edge.

Configuration
REQ-022 SHALL use macro INPUT_SYNC_DEBOUNCE_EN to include a per-bit debounce stage between chain output and Q.
REQ-023 SHALL, with INPUT_SYNC_DEBOUNCE_EN defined, update Q[i] only after the chain output differs from Q[i] on DEBOUNCE_CYC consecutive CE edges; any return to equality clears that bit's counter; latency grows by DEBOUNCE_CYC cycles.
REQ-024 SHALL, without INPUT_SYNC_DEBOUNCE_EN, contain no debounce counters, ignore DEBOUNCE_CYC, and match REQ-013 latency exactly.

Structure
REQ-025 SHALL place SRMODE encoding constants, WIDTH/STAGES/DEBOUNCE_CYC limits and the counter-width function in shared package input_sync_pkg.
REQ-026 SHALL implement one bit lane (chain, optional debounce, edge detect) as sub-module input_sync_bit, instantiated WIDTH times; the VALID counter lives in the top.
REQ-027 SHALL flag illegal parameter values at elaboration.

Verification
REQ-028 SHALL test latency: WIDTH=8, STAGES=2, CE=1, D 0x00->0xA5 at edge 10 -> Q=0xA5 after edge 11, RISE=0xA5 for one cycle, FALL=0.
REQ-029 SHALL test CE gating: CE low for 5 cycles while D toggles -> Q, VALID frozen, RISE=FALL=0; on CE high the chain resumes.
REQ-030 SHALL test PRESET reset: SRMODE="PRESET", LSR pulse -> Q=0xFF, VALID=0; D=0x00 held -> FALL=0x00 until VALID, then FALL=0xFF one cycle.
REQ-031 SHALL test debounce with macro: DEBOUNCE_CYC=4, D[0] high 3 cycles then low -> Q[0] unchanged; high 6 cycles -> Q[0]=1 after edge STAGES+4 from first sample.
REQ-032 SHALL test reset mid-operation: LSR during a debounce window and during chain fill -> all outputs at reset values next cycle, no spurious RISE/FALL afterwards.

Source files
------------

// File: rtl/input_sync_pkg.sv
// input_sync_pkg: shared constants and helpers for the input synchronizer.
// Holds the SRMODE reset-value encodings, legal ranges for WIDTH, STAGES and
// DEBOUNCE_CYC, and the counter-width function used by the top and bit lanes.
package input_sync_pkg;

  // Reset-value selectors: CLEAR resets all state to 0, PRESET resets it to 1.
  localparam string SRMODE_CLEAR  = "CLEAR";
  localparam string SRMODE_PRESET = "PRESET";

  localparam int WIDTH_MIN    = 1;
  localparam int WIDTH_MAX    = 64;
  localparam int STAGES_MIN   = 2;
  localparam int STAGES_MAX   = 4;
  localparam int DEBOUNCE_MIN = 1;
  localparam int DEBOUNCE_MAX = 255;

  // Number of bits needed to hold the value max_val (at least 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((max_val >> w) != 0) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/input_sync_if.sv
// input_sync_if: data bus of the input synchronizer.
// Ports: CE (clock enable), D (async inputs), Q (synchronized value),
// RISE/FALL (per-bit edge pulses of Q), VALID (chain holds real samples).
interface input_sync_if #(
  parameter int WIDTH = 8
) ();

  logic             CE;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic             VALID;

  // master drives the asynchronous inputs and enable, slave is the synchronizer.
  modport master (output CE, D, input Q, RISE, FALL, VALID);
  modport slave  (input CE, D, output Q, RISE, FALL, VALID);

endinterface

// File: rtl/input_sync_bit.sv
// input_sync_bit: one bit lane -- synchronizer chain, optional debounce, edge detect.
// Ports: i_clk, i_rst (sync active-high), i_ce, i_valid_nxt (VALID after this edge),
// i_d (async bit), o_q (synced bit), o_rise/o_fall (one-cycle edge pulses).
// Optional debounce stage compiled in with macro INPUT_SYNC_DEBOUNCE_EN.
module input_sync_bit
  import input_sync_pkg::*;
#(
  parameter int STAGES       = 2,
`ifdef INPUT_SYNC_DEBOUNCE_EN
  parameter int DEBOUNCE_CYC = 4,
`endif
  parameter bit RST_VAL      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ce,
  input  logic i_valid_nxt,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_rise;
  logic              r_fall;
  logic              w_q;      // Q as currently registered
  logic              w_q_nxt;  // Q as it will be after this edge

`ifdef INPUT_SYNC_DEBOUNCE_EN
  localparam int             DW      = cnt_width(DEBOUNCE_CYC);
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          r_q;
  logic [DW-1:0] r_db_cnt;
  logic          w_diff;

  assign w_diff  = r_chain[STAGES-1] ^ r_q;
  assign w_q     = r_q;
  // Q follows the chain only on the DEBOUNCE_CYC-th consecutive differing CE edge.
  assign w_q_nxt = (i_ce && w_diff && (r_db_cnt == DB_LAST)) ? r_chain[STAGES-1] : r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q      <= RST_VAL;
      r_db_cnt <= '0;
    end else if (i_ce) begin
      r_q <= w_q_nxt;
      // Any return to equality (or the update itself) restarts the window.
      if (!w_diff || (r_db_cnt == DB_LAST)) r_db_cnt <= '0;
      else                                  r_db_cnt <= r_db_cnt + 1'b1;
    end
  end
`else
  assign w_q     = r_chain[STAGES-1];
  assign w_q_nxt = i_ce ? r_chain[STAGES-2] : r_chain[STAGES-1];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= {STAGES{RST_VAL}};
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_ce) begin
        r_chain <= {r_chain[STAGES-2:0], i_d};
        // Pulses line up with the cycle Q changes; gated by the post-edge VALID
        // so the transition that completes the fill is still reported.
        r_rise  <= i_valid_nxt &  w_q_nxt & ~w_q;
        r_fall  <= i_valid_nxt & ~w_q_nxt &  w_q;
      end
    end
  end

  assign o_q    = w_q;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/input_sync_reg.sv
// input_sync_reg: multi-bit input synchronizer with edge pulses and VALID flag.
// Ports: SCLK (clock), LSR (sync active-high reset), bus (input_sync_if.slave:
// CE, D in; Q, RISE, FALL, VALID out). Debounce enabled by INPUT_SYNC_DEBOUNCE_EN.
module input_sync_reg
  import input_sync_pkg::*;
#(
  parameter int    WIDTH        = 8,
  parameter int    STAGES       = 2,
  parameter string SRMODE       = "CLEAR",
  parameter int    DEBOUNCE_CYC = 4
) (
  input  logic         SCLK,
  input  logic         LSR,
  input_sync_if.slave  bus
);

  localparam int            CW      = cnt_width(STAGES);
  localparam logic [CW-1:0] C_FULL  = CW'(STAGES);
  localparam bit            RST_VAL = (SRMODE == SRMODE_PRESET);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("input_sync_reg: WIDTH=%0d out of range 1..64", WIDTH);
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("input_sync_reg: STAGES=%0d out of range 2..4", STAGES);
  end
  if (SRMODE != SRMODE_CLEAR && SRMODE != SRMODE_PRESET) begin : g_bad_srmode
    $error("input_sync_reg: SRMODE must be CLEAR or PRESET");
  end
  // Range is checked in both builds so a configuration stays portable when
  // debounce is switched on.
  if (DEBOUNCE_CYC < DEBOUNCE_MIN || DEBOUNCE_CYC > DEBOUNCE_MAX) begin : g_bad_db
    $error("input_sync_reg: DEBOUNCE_CYC=%0d out of range 1..255", DEBOUNCE_CYC);
  end

  // Reset is stretched by one edge: the first edge after LSR falls still
  // holds reset values, operation resumes on the following CE edge.
  logic          r_lsr_d;
  logic          w_rst;
  logic [CW-1:0] r_ce_cnt;
  logic [CW-1:0] w_ce_cnt_nxt;
  logic          w_valid_nxt;
  logic          r_valid;

  always_ff @(posedge SCLK) begin
    r_lsr_d <= LSR;
  end

  assign w_rst = LSR | r_lsr_d;

  always_comb begin
    w_ce_cnt_nxt = r_ce_cnt;
    if (bus.CE && (r_ce_cnt != C_FULL)) w_ce_cnt_nxt = r_ce_cnt + 1'b1;
    w_valid_nxt  = (w_ce_cnt_nxt == C_FULL);
  end

  always_ff @(posedge SCLK) begin
    if (w_rst) begin
      r_ce_cnt <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_ce_cnt <= w_ce_cnt_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    input_sync_bit #(
      .STAGES       (STAGES),
`ifdef INPUT_SYNC_DEBOUNCE_EN
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
`endif
      .RST_VAL      (RST_VAL)
    ) u_bit (
      .i_clk       (SCLK),
      .i_rst       (w_rst),
      .i_ce        (bus.CE),
      .i_valid_nxt (w_valid_nxt),
      .i_d         (bus.D[i]),
      .o_q         (w_q[i]),
      .o_rise      (w_rise[i]),
      .o_fall      (w_fall[i])
    );
  end

  assign bus.Q     = w_q;
  assign bus.RISE  = w_rise;
  assign bus.FALL  = w_fall;
  assign bus.VALID = r_valid;

endmodule
